ibuf_fetch_ctrl: RTL and testbench

Fetch sequencer that fills the instruction buffer. It issues aligned fetch-group requests to the I-cache under a credit check against buffer occupancy. Returning groups are compacted into a contiguous low-order write mask with per-slot PCs. On a redirect it flushes the buffer and discards stale in-flight responses. It sits between the PC/redirect logic and the I-cache on one side, and the instruction buffer (inst/pc/wen/clr/count) on the other.

---
 rtl/ibuf_pkg.sv | 8 +
 rtl/ibuf_group_align.sv | 22 ++
 rtl/ibuf_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_ibuf_fetch_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ibuf_pkg.sv
// Shared constants and FSM state encoding for the instruction-buffer fetch sequencer.
package ibuf_pkg;
  localparam int FETCH_NUM = 4;
  localparam int OFS_W     = $clog2(FETCH_NUM);
  localparam int BOFS_W    = $clog2(FETCH_NUM * 4);

  typedef enum logic {RUN, DRAIN} fetch_state_e;
endpackage

// File: rtl/ibuf_group_align.sv
// Compacts a fetch group starting at slot k down to slot 0 and generates per-slot PCs and write mask.
module ibuf_group_align
  import ibuf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]           base_i,
  input  logic [OFS_W-1:0]                k_i,
  input  logic [FETCH_NUM*DATA_WIDTH-1:0] data_i,
  output logic [FETCH_NUM*DATA_WIDTH-1:0] inst_o,
  output logic [FETCH_NUM*ADDR_WIDTH-1:0] pc_o,
  output logic [FETCH_NUM-1:0]            wen_o
);
  // Shifting right zero-fills the slots past the end of the group.
  assign inst_o = data_i >> (DATA_WIDTH * int'(k_i));

  for (genvar j = 0; j < FETCH_NUM; j++) begin : g_slot
    assign pc_o[j*ADDR_WIDTH +: ADDR_WIDTH] = base_i + ADDR_WIDTH'(4 * j) + (ADDR_WIDTH'(k_i) << 2);
    assign wen_o[j] = (j + int'(k_i)) < FETCH_NUM;
  end
endmodule

// File: rtl/ibuf_fetch_ctrl.sv
// Fetch sequencer: credit-checked I-cache requests, in-order response compaction, redirect flush/drain.
module ibuf_fetch_ctrl
  import ibuf_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DEPTH           = 32,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'h8000_0000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            redirect_valid,
  input  logic [ADDR_WIDTH-1:0]           redirect_pc,
  output logic                            req_valid,
  input  logic                            req_ready,
  output logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic                            resp_valid,
  input  logic [FETCH_NUM*DATA_WIDTH-1:0] resp_data,
  output logic [FETCH_NUM*DATA_WIDTH-1:0] inst_o,
  output logic [FETCH_NUM*ADDR_WIDTH-1:0] pc_o,
  output logic [FETCH_NUM-1:0]            inst_wen,
  output logic                            buf_clr,
  input  logic [$clog2(DEPTH)-1:0]        inst_count
);
  localparam int CW    = $clog2(DEPTH) + 3;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [OUT_W-1:0]      outs_q, outs_d, drop_q, redir_drop;
  logic [PTR_W-1:0]      wptr_q, rptr_q;
  // Entries hold the word address of each request: group base plus start slot.
  logic [ADDR_WIDTH-3:0] ofs_fifo_q [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-3:0] head;
  logic [CW-1:0]         need;
  logic                  credit, req_fire, resp_fire;
  logic [FETCH_NUM-1:0]  al_wen;
  logic                  unused_pc_lo;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Occupancy is taken as-is: reads draining the buffer this cycle are not credited.
  assign need      = CW'(inst_count) + CW'(FETCH_NUM) * (CW'(outs_q) + CW'(1));
  assign credit    = need <= CW'(DEPTH - 1);
  assign req_valid = (state_q == RUN) & credit & (outs_q < OUT_W'(MAX_OUTSTANDING)) & ~redirect_valid;
  assign req_addr  = {fetch_pc_q[ADDR_WIDTH-1:BOFS_W], {BOFS_W{1'b0}}};
  assign req_fire  = req_valid & req_ready;

  assign resp_fire    = resp_valid & (drop_q == '0) & ~redirect_valid;
  assign redir_drop   = outs_q - OUT_W'(resp_valid);
  assign head         = ofs_fifo_q[rptr_q];
  assign buf_clr      = redirect_valid;
  assign inst_wen     = resp_fire ? al_wen : '0;
  assign unused_pc_lo = ^fetch_pc_q[1:0];

  ibuf_group_align #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_align (
    .base_i (ADDR_WIDTH'({head[ADDR_WIDTH-3:BOFS_W-2], {BOFS_W{1'b0}}})),
    .k_i    (head[OFS_W-1:0]),
    .data_i (resp_data),
    .inst_o (inst_o),
    .pc_o   (pc_o),
    .wen_o  (al_wen)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)
      fetch_pc_d = redirect_pc;
    else if (req_fire)
      fetch_pc_d = req_addr + ADDR_WIDTH'(FETCH_NUM * 4);
    outs_d = outs_q + OUT_W'(req_fire) - OUT_W'(resp_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      outs_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outs_q     <= outs_d;
      if (req_fire)   wptr_q <= ptr_inc(wptr_q);
      if (resp_valid) rptr_q <= ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) ofs_fifo_q[wptr_q] <= fetch_pc_q[ADDR_WIDTH-1:2];
  end

  // The offset FIFO is never flushed; drop_q just counts how many of its heads are stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drop_q  <= '0;
    end else if (redirect_valid) begin
      drop_q  <= redir_drop;
      state_q <= (redir_drop != '0) ? DRAIN : RUN;
    end else if (resp_valid && drop_q != '0) begin
      drop_q <= drop_q - OUT_W'(1);
      if (drop_q == OUT_W'(1)) state_q <= RUN;
    end
  end

  a_resp_legal: assert property (@(posedge clk) disable iff (rst) !(resp_valid && outs_q == '0))
    else $error("resp_valid with no request outstanding");
endmodule

// File: tb/tb_ibuf_fetch_ctrl.sv
// Randomized bench for ibuf_fetch_ctrl: in-flight-list reference model with a write scoreboard.
module tb_ibuf_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst, redirect_valid, req_ready, resp_valid;
  logic [31:0]  redirect_pc;
  logic [127:0] resp_data;
  logic [4:0]   inst_count;
  logic         req_valid, buf_clr;
  logic [31:0]  req_addr;
  logic [127:0] inst_o, pc_o;
  logic [3:0]   inst_wen;

  always #5 clk = ~clk;

  ibuf_fetch_ctrl dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .inst_o(inst_o), .pc_o(pc_o),
    .inst_wen(inst_wen), .buf_clr(buf_clr), .inst_count(inst_count)
  );

  typedef struct { logic [31:0] addr; bit stale; } flight_t;
  typedef struct { int cyc; logic [3:0] wen; logic [127:0] inst; logic [127:0] pc; } exp_t;

  flight_t     fl[$];
  exp_t        sb[$];
  exp_t        me;
  logic [31:0] m_pc = RESET_PC;
  int          cyc = 0, n_chk = 0, n_fail = 0;
  bit          chk_en = 0;

  logic        d_rst = 0, d_redir = 0, d_ready = 1, d_resp = 0;
  logic [31:0] d_rpc = '0;
  logic [4:0]  d_cnt = '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [127:0] dat;
    logic [31:0]  exp_addr, base;
    logic         exp_rv, r;
    bit           stale_any;
    int           k;
    exp_t         e;
    @(negedge clk);
    cyc++;
    r   = d_resp && !d_rst && fl.size() != 0;
    dat = {$urandom, $urandom, $urandom, $urandom};
    rst = d_rst; redirect_valid = d_redir; redirect_pc = d_rpc; req_ready = d_ready;
    resp_valid = r; resp_data = dat; inst_count = d_cnt;
    stale_any = 0;
    foreach (fl[i]) if (fl[i].stale) stale_any = 1;
    exp_rv   = !d_redir && !stale_any && fl.size() < 2 && (int'(d_cnt) + 4 * (fl.size() + 1) <= 31);
    exp_addr = m_pc & 32'hFFFF_FFF0;
    if (r && !d_redir && !fl[0].stale) begin
      k    = int'(fl[0].addr[3:2]);
      base = fl[0].addr & 32'hFFFF_FFF0;
      e.cyc = cyc; e.wen = '0; e.inst = '0; e.pc = '0;
      for (int j = 0; j < 4; j++) begin
        e.pc[j*32 +: 32] = base + 32'(4 * (j + k));
        if (j + k < 4) begin
          e.wen[j] = 1'b1;
          e.inst[j*32 +: 32] = dat[(j+k)*32 +: 32];
        end
      end
      sb.push_back(e);
    end
    #1;
    if (chk_en) begin
      if (!d_rst || fl.size() == 2) check("req_valid", req_valid, exp_rv);
      if (exp_rv && req_valid) check("req_addr", req_addr, exp_addr);
      check("buf_clr", buf_clr, d_redir);
    end
    @(posedge clk);
    if (d_rst) begin
      fl.delete();
      m_pc = RESET_PC;
    end else begin
      if (r) void'(fl.pop_front());
      if (d_redir) begin
        foreach (fl[i]) fl[i].stale = 1;
        m_pc = d_rpc;
      end else if (exp_rv && d_ready) begin
        fl.push_back('{m_pc, 1'b0});
        m_pc = exp_addr + 32'd16;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every buffer write must match the oldest expected write for this cycle.
  initial forever begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      if (inst_wen !== 4'b0) begin
        if (sb.size() == 0) check("unexpected_wen", inst_wen, 4'b0);
        else begin
          me = sb.pop_front();
          check("wr_cycle", cyc, me.cyc);
          check("inst_wen", inst_wen, me.wen);
          check("inst_o", inst_o, me.inst);
          check("pc_o", pc_o, me.pc);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        me = sb.pop_front();
        check("inst_wen_missing", inst_wen, me.wen);
      end
    end
  end

  initial begin
    d_rst = 1; run(2);
    chk_en = 1;
    d_rst = 0;
    // streaming fetch from reset PC with 1-cycle responses
    d_ready = 1; d_resp = 1; run(6);
    d_ready = 0; run(3);
    // redirect to mid-group address with nothing in flight
    d_redir = 1; d_rpc = 32'h8000_0108; run(1);
    d_redir = 0; d_ready = 1; d_resp = 0; run(1);
    d_ready = 0; d_resp = 1; run(2);
    // redirect with two in flight: both responses dropped
    d_ready = 1; d_resp = 0; run(2);
    d_redir = 1; d_rpc = 32'h8000_0200; run(1);
    d_redir = 0; run(1);
    d_resp = 1; d_ready = 0; run(2);
    d_resp = 0; d_ready = 1; run(1);
    d_ready = 0; d_resp = 1; run(2);
    // credit boundary: 23 passes with 1 outstanding, 24 does not
    d_cnt = 5'd23; d_ready = 1; d_resp = 0; run(2);
    d_ready = 0; d_resp = 1; run(2);
    d_cnt = 5'd24; d_ready = 1; d_resp = 0; run(2);
    d_cnt = 5'd28; run(1);
    d_cnt = 5'd0; d_ready = 0; d_resp = 1; run(2);
    // redirect coincident with response, one outstanding
    d_ready = 1; d_resp = 0; run(1);
    d_redir = 1; d_rpc = 32'h8000_0300; d_resp = 1; run(1);
    d_redir = 0; d_resp = 0; run(1);
    d_ready = 0; d_resp = 1; run(2);
    // reset with two outstanding
    d_ready = 1; d_resp = 0; run(2);
    d_rst = 1; run(1);
    d_rst = 0; run(2);
    d_ready = 0; d_resp = 1; run(3);
    // randomized traffic including wrap-around redirects and occasional reset
    for (int i = 0; i < 4000; i++) begin
      d_ready = ($urandom % 4) != 0;
      d_resp  = ($urandom % 3) != 0;
      d_redir = ($urandom % 25) == 0;
      d_rpc   = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                    : (32'h8000_0000 + 32'($urandom_range(0, 255) * 4));
      d_cnt   = ($urandom % 2) ? 5'($urandom_range(0, 12)) : 5'($urandom_range(0, 31));
      d_rst   = ($urandom % 500) == 0;
      step();
    end
    d_rst = 0; d_redir = 0; d_ready = 0; d_resp = 1; run(4);
    @(negedge clk);
    #3;
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
